// File: rtl/hitegg_game_ctrl_if.sv
// Control/status bundle between the hit-egg sequencer and its input debouncers / display drivers.
// The master side drives start/pause/hit pulses; the slave (sequencer) drives the game status.
interface hitegg_game_ctrl_if #(
  parameter int N_HOLES = 8
);
  logic               start;
  logic               pause;
  logic [N_HOLES-1:0] hit;
  logic [N_HOLES-1:0] egg;
  logic [5:0]         time_left;
  logic [7:0]         score;
  logic [1:0]         state;
  logic               tick;
  logic               over;

  modport master (
    output start, pause, hit,
    input  egg, time_left, score, state, tick, over
  );

  modport slave (
    input  start, pause, hit,
    output egg, time_left, score, state, tick, over
  );
endinterface

// File: rtl/hitegg_game_ctrl.sv
// Hit-egg game sequencer: IDLE/RUN/PAUSE/OVER FSM, seconds countdown, LFSR egg placement and scoring.
// Optional macro MISS_PENALTY_EN: a wrong-hole hit in RUN costs one point (saturating at 0).
module hitegg_game_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int GAME_SECS = 60,
  parameter int N_HOLES   = 8,
  parameter int EGG_LIFE  = 700
) (
  input  logic            clk,
  input  logic            rst,
  hitegg_game_ctrl_if.slave bus
);

  localparam int IDX_W  = $clog2(N_HOLES);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int EGG_W  = $clog2(EGG_LIFE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         time_left_q, time_left_d;
  logic [7:0]         score_q, score_d;
  logic [N_HOLES-1:0] egg_q, egg_d;
  logic [IDX_W-1:0]   hole_q, hole_d;
  logic [TICK_W-1:0]  presc_q, presc_d;
  logic [EGG_W-1:0]   egg_tmr_q, egg_tmr_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               tick_q, tick_d;
  logic               over_q, over_d;

  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   respawn_idx;
  logic               hit_ok;

  function automatic logic [N_HOLES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_HOLES-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] s);
    return (s == 8'h00) ? s : s - 8'd1;
  endfunction

  // A respawn never lands on the hole that was just lit
  assign cand_idx    = lfsr_q[IDX_W-1:0];
  assign respawn_idx = (cand_idx == hole_q) ? cand_idx + IDX_W'(1) : cand_idx;
  assign hit_ok      = |(bus.hit & egg_q);

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    egg_d       = egg_q;
    hole_d      = hole_q;
    presc_d     = presc_q;
    egg_tmr_d   = egg_tmr_q;
    tick_d      = 1'b0;
    over_d      = over_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    unique case (state_q)
      S_IDLE: begin
        egg_d  = '0;
        over_d = 1'b0;
        if (bus.start) begin
          state_d     = S_RUN;
          time_left_d = 6'(GAME_SECS);
          score_d     = 8'd0;
          presc_d     = '0;
          egg_tmr_d   = '0;
          hole_d      = cand_idx;
          egg_d       = onehot(cand_idx);
        end
      end

      S_RUN: begin
        if (hit_ok) begin
          score_d = sat_inc(score_q);
`ifdef MISS_PENALTY_EN
        end else if (|bus.hit) begin
          score_d = sat_dec(score_q);
`endif
        end

        if (hit_ok || (egg_tmr_q == EGG_W'(EGG_LIFE - 1))) begin
          hole_d    = respawn_idx;
          egg_d     = onehot(respawn_idx);
          egg_tmr_d = '0;
        end else begin
          egg_tmr_d = egg_tmr_q + EGG_W'(1);
        end

        // The last second ending beats everything else in the same cycle
        if (presc_q == TICK_W'(TICK_DIV - 1)) begin
          presc_d     = '0;
          tick_d      = 1'b1;
          time_left_d = time_left_q - 6'd1;
          if (time_left_q == 6'd1) begin
            state_d = S_OVER;
            over_d  = 1'b1;
            egg_d   = '0;
          end
        end else begin
          presc_d = presc_q + TICK_W'(1);
        end

        if (bus.pause && (state_d == S_RUN)) begin
          state_d = S_PAUSE;
          egg_d   = '0;
        end
      end

      S_PAUSE: begin
        egg_d = '0;
        if (bus.pause) begin
          state_d = S_RUN;
          egg_d   = onehot(hole_q);
        end
      end

      S_OVER: begin
        egg_d       = '0;
        over_d      = 1'b1;
        time_left_d = 6'd0;
        if (bus.start) begin
          state_d     = S_IDLE;
          over_d      = 1'b0;
          time_left_d = 6'(GAME_SECS);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      time_left_q <= 6'(GAME_SECS);
      score_q     <= 8'd0;
      egg_q       <= '0;
      hole_q      <= '0;
      presc_q     <= '0;
      egg_tmr_q   <= '0;
      lfsr_q      <= 8'hA5;
      tick_q      <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      score_q     <= score_d;
      egg_q       <= egg_d;
      hole_q      <= hole_d;
      presc_q     <= presc_d;
      egg_tmr_q   <= egg_tmr_d;
      lfsr_q      <= lfsr_d;
      tick_q      <= tick_d;
      over_q      <= over_d;
    end
  end

  assign bus.egg       = egg_q;
  assign bus.time_left = time_left_q;
  assign bus.score     = score_q;
  assign bus.state     = state_q;
  assign bus.tick      = tick_q;
  assign bus.over      = over_q;

endmodule

// File: tb/tb_hitegg_game_ctrl.sv
// Directed bench for hitegg_game_ctrl: a per-cycle table for the game timeline plus hand sequences
// for hits, expiry, pause, wrong-hole hits, score saturation and asynchronous reset.
module tb_hitegg_game_ctrl;
  localparam int TD = 4, GS = 3, NH = 8, EL = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hitegg_game_ctrl_if #(.N_HOLES(NH)) bus ();
  hitegg_game_ctrl_if #(.N_HOLES(NH)) sbus ();

  hitegg_game_ctrl #(.TICK_DIV(TD), .GAME_SECS(GS), .N_HOLES(NH), .EGG_LIFE(EL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  // Long-game instance: same LFSR sequence, used where the short game is too brief
  hitegg_game_ctrl #(.TICK_DIV(400), .GAME_SECS(63), .N_HOLES(NH), .EGG_LIFE(EL)) dut_sat (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] m_lfsr;
  logic [2:0] cand;

  typedef struct {
    logic       s;
    logic       p;
    logic [1:0] st;
    logic [5:0] tl;
    logic       tk;
    logic       ov;
    logic       egg0;
  } vec_t;
  vec_t tbl[16];

  function automatic logic [7:0] lfsr_nx(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] r;
    r    = 8'h00;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [2:0] resp(input logic [2:0] c, input logic [2:0] h);
    return (c == h) ? c + 3'd1 : c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // cand holds the LFSR's hole index as seen by the edge this call clocks
  task automatic cyc(input logic s, input logic p, input logic [7:0] h);
    bus.start = s;
    bus.pause = p;
    bus.hit   = h;
    cand      = m_lfsr[2:0];
    @(posedge clk);
    if (!rst) m_lfsr = lfsr_nx(m_lfsr);
    #1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.hit   = '0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m_lfsr = 8'hA5;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] h, sh;
    logic [7:0] wrong;
    int exp_sc;

    bus.start = 0; bus.pause = 0; bus.hit = '0;
    sbus.start = 0; sbus.pause = 0; sbus.hit = '0;

    tbl[0]  = '{1'b1, 1'b0, 2'd1, 6'd3, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 2'd1, 6'd3, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd1, 6'd3, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'd1, 6'd3, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 6'd2, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 2'd1, 6'd2, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 2'd1, 6'd2, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'd1, 6'd2, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'd1, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'd1, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd1, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'd1, 6'd1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2'd3, 6'd0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 2'd3, 6'd0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 2'd0, 6'd3, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 2'd1, 6'd3, 1'b0, 1'b0, 1'b0};

    // Reset values
    do_reset();
    chk("rst_state", bus.state, 0);
    chk("rst_time", bus.time_left, GS);
    chk("rst_score", bus.score, 0);
    chk("rst_egg", bus.egg, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_over", bus.over, 0);

    // Asynchronous reset mid-RUN with score 5, time_left 2
    cyc(1, 0, 0);
    h = cand;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, oh(h));
      h = resp(cand, h);
    end
    chk("mid_score", bus.score, 5);
    chk("mid_time", bus.time_left, 2);
    chk("mid_state", bus.state, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_state", bus.state, 0);
    chk("arst_score", bus.score, 0);
    chk("arst_time", bus.time_left, GS);
    chk("arst_egg", bus.egg, 0);
    chk("arst_over", bus.over, 0);
    #1 rst = 1'b0;
    m_lfsr = 8'hA5;

    // Full game timeline, then OVER -> IDLE -> RUN
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].s, tbl[i].p, 0);
      chk($sformatf("tbl%0d_state", i), bus.state, tbl[i].st);
      chk($sformatf("tbl%0d_time", i), bus.time_left, tbl[i].tl);
      chk($sformatf("tbl%0d_tick", i), bus.tick, tbl[i].tk);
      chk($sformatf("tbl%0d_over", i), bus.over, tbl[i].ov);
      chk($sformatf("tbl%0d_score", i), bus.score, 0);
      if (tbl[i].egg0) chk($sformatf("tbl%0d_egg0", i), bus.egg, 0);
      else             chk($sformatf("tbl%0d_egg1h", i), $onehot(bus.egg), 1);
    end

    // Hit on the lit hole, and score saturation on the long-game instance
    do_reset();
    sbus.start = 1'b1;
    cyc(1, 0, 0);
    sbus.start = 1'b0;
    h = cand;
    chk("first_egg", bus.egg, oh(h));
    cyc(0, 0, oh(h));
    chk("hit_score", bus.score, 1);
    chk("hit_moved", bus.egg != oh(h), 1);
    h = resp(cand, h);
    chk("hit_new_egg", bus.egg, oh(h));
    for (int n = 1; n <= 260; n++) begin
      sbus.hit = sbus.egg;
      cyc(0, 0, 0);
      sbus.hit = '0;
      if (n == 1 || n == 254 || n == 255 || n == 256 || n == 260)
        chk($sformatf("sat_score_n%0d", n), sbus.score, (n > 255) ? 255 : n);
    end

    // Expiry without hits: exact placement, then hit coinciding with expiry
    do_reset();
    sbus.start = 1'b1;
    cyc(1, 0, 0);
    sbus.start = 1'b0;
    h  = cand;
    sh = cand;
    for (int k = 1; k <= 39; k++) begin
      cyc(0, 0, 0);
      if (k % 10 == 0) begin
        chk($sformatf("exp_differs_k%0d", k), resp(cand, sh) != sh, 1);
        sh = resp(cand, sh);
      end
      if (k == 10) h = resp(cand, h);
      chk($sformatf("exp_sat_egg_k%0d", k), sbus.egg, oh(sh));
      if (k <= 11) chk($sformatf("exp_egg_k%0d", k), bus.egg, oh(h));
    end
    sbus.hit = oh(sh);
    cyc(0, 0, 0);
    sbus.hit = '0;
    sh = resp(cand, sh);
    chk("hitexp_score", sbus.score, 1);
    chk("hitexp_egg", sbus.egg, oh(sh));
    cyc(0, 0, 0);
    chk("hitexp_single", sbus.egg, oh(sh));

    // Pause two cycles into a second; resume; tick coinciding with pause
    do_reset();
    cyc(1, 0, 0);
    h = cand;
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("pause_state", bus.state, 2);
    chk("pause_egg", bus.egg, 0);
    for (int i = 0; i < 20; i++) begin
      cyc((i == 5), 0, 8'hFF);
      chk($sformatf("paused_state_%0d", i), bus.state, 2);
      chk($sformatf("paused_egg_%0d", i), bus.egg, 0);
      chk($sformatf("paused_tick_%0d", i), bus.tick, 0);
    end
    chk("paused_time", bus.time_left, 3);
    chk("paused_score", bus.score, 0);
    cyc(0, 1, 0);
    chk("resume_state", bus.state, 1);
    chk("resume_egg", bus.egg, oh(h));
    chk("resume_tick0", bus.tick, 0);
    cyc(0, 0, 0);
    chk("resume_tick1", bus.tick, 0);
    cyc(0, 1, 0);
    chk("tickpause_tick", bus.tick, 1);
    chk("tickpause_time", bus.time_left, 2);
    chk("tickpause_state", bus.state, 2);
    chk("tickpause_egg", bus.egg, 0);
    cyc(1, 1, 0);
    chk("startpause_state", bus.state, 1);
    chk("startpause_egg", bus.egg, oh(h));

    // Wrong-hole hits and multi-bit hits
    do_reset();
    cyc(1, 0, 0);
    h = cand;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, oh(h));
      h = resp(cand, h);
    end
    chk("pre_wrong_score", bus.score, 2);
    wrong = oh(h + 3'd1);
    cyc(0, 0, wrong);
`ifdef MISS_PENALTY_EN
    exp_sc = 1;
`else
    exp_sc = 2;
`endif
    chk("wrong_score", bus.score, exp_sc);
    chk("wrong_no_respawn", bus.egg, oh(h));
`ifdef MISS_PENALTY_EN
    cyc(0, 0, wrong);
    chk("wrong_to_zero", bus.score, 0);
    cyc(0, 0, wrong);
    chk("wrong_sat_zero", bus.score, 0);
    exp_sc = 0;
`endif
    cyc(0, 0, oh(h) | wrong);
    chk("multi_hit_score", bus.score, exp_sc + 1);
    h = resp(cand, h);
    chk("multi_hit_egg", bus.egg, oh(h));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
